// File: rtl/alu_system_sequencer.sv
// Hardwired fetch/fetch/execute control unit for the ArithmeticLogicUnitSystem datapath.
// Optional single-step mode (Step input, WAIT state) enabled by defining ALU_SEQ_STEP_EN.
module alu_system_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
`ifdef ALU_SEQ_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IROut,
  input  logic        Z,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Busy,
  output logic        Halted
);

  // PC preload lives in the ARF; the parameter is kept only for the top-level bench.
  logic unusedResetPc;
  assign unusedResetPc = ^RESET_PC;

`ifdef ALU_SEQ_STEP_EN
  typedef enum logic [2:0] {IDLE, T0, T1, T2, HALT, WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, T0, T1, T2, HALT} state_t;
`endif

  state_t state, nextState;

  // Destination Rn (n = idx+1) maps to a single low bit, R1 at the MSB.
  function automatic logic [3:0] regSelFor(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

`ifdef ALU_SEQ_STEP_EN
  logic stepPrev;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) stepPrev <= 1'b0;
    else       stepPrev <= Step;
  end
`endif

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (Start) nextState = T0;
      T0:   nextState = T1;
      T1:   nextState = T2;
      T2: begin
        if (IROut[15:14] == 2'b11) nextState = HALT;
`ifdef ALU_SEQ_STEP_EN
        else                       nextState = WAIT;
`else
        else                       nextState = T0;
`endif
      end
      HALT: nextState = HALT;
`ifdef ALU_SEQ_STEP_EN
      WAIT: if (Step && !stepPrev) nextState = T0;
`endif
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_FunSel   = '0;
    RF_RegSel   = '1;
    RF_ScrSel   = '1;
    ALU_FunSel  = '0;
    ALU_WF      = 1'b0;
    ARF_OutCSel = '0;
    ARF_OutDSel = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = '1;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = 1'b0;
    Busy        = 1'b0;
    Halted      = 1'b0;
    unique case (state)
      T0, T1: begin
        Busy        = 1'b1;
        Mem_CS      = 1'b0;
        ARF_OutDSel = 2'b00;
        IR_Write    = 1'b1;
        IR_LH       = (state == T1);
        ARF_RegSel  = 3'b011;
        ARF_FunSel  = 3'b001;
      end
      T2: begin
        Busy = 1'b1;
        unique case (IROut[15:14])
          2'b00: begin
            ALU_FunSel = IROut[13:9];
            RF_OutASel = IROut[6:4];
            RF_OutBSel = IROut[3:1];
            ALU_WF     = IROut[0];
            MuxASel    = 2'b00;
            RF_FunSel  = 3'b010;
            RF_RegSel  = regSelFor(IROut[8:7]);
          end
          2'b01: begin
            MuxASel   = 2'b11;
            RF_FunSel = 3'b010;
            RF_RegSel = regSelFor(IROut[9:8]);
          end
          2'b10: begin
            if (!IROut[13] || Z) begin
              MuxBSel    = 2'b11;
              ARF_FunSel = 3'b010;
              ARF_RegSel = 3'b011;
            end
          end
          default: ;
        endcase
      end
      HALT:    Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_system_sequencer.sv
// Randomized self-checking bench for alu_system_sequencer against a phase-based reference model.
// Build with ALU_SEQ_STEP_EN defined to exercise the single-step mode as well.
module tb_alu_system_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        StepIn = 1'b0;
  logic [15:0] IROut = '0;
  logic        Z = 1'b0;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Busy, Halted;

  int unsigned nCmp = 0;
  int unsigned nBad = 0;
  // Model phase: 0 idle, 1 fetch low, 2 fetch high, 3 execute, 4 halted, 5 waiting for Step.
  int          phase = 0;
  logic        prevStep = 1'b0;

`ifdef ALU_SEQ_STEP_EN
  localparam bit STEP_MODE = 1'b1;
`else
  localparam bit STEP_MODE = 1'b0;
`endif

  alu_system_sequencer #(.RESET_PC(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
`ifdef ALU_SEQ_STEP_EN
    .Step(StepIn),
`endif
    .IROut(IROut), .Z(Z),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .Busy(Busy), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  logic [41:0] obsCtrl;
  assign obsCtrl = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
                    ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
                    IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

  function automatic logic [41:0] modelCtrl(input int ph, input logic [15:0] ir, input logic z);
    logic [2:0] oa = 3'd0, ob = 3'd0, rfFun = 3'd0, arfFun = 3'd0, arfReg = 3'b111;
    logic [3:0] rfReg = 4'hF, scr = 4'hF;
    logic [4:0] aluFun = 5'd0;
    logic [1:0] oc = 2'd0, od = 2'd0, ma = 2'd0, mb = 2'd0;
    logic wf = 1'b0, lh = 1'b0, irw = 1'b0, wr = 1'b0, cs = 1'b1, mc = 1'b0;
    int cls = int'(ir[15:14]);
    if (ph == 1 || ph == 2) begin
      cs = 1'b0; irw = 1'b1; lh = (ph == 2); arfReg = 3'b011; arfFun = 3'b001;
    end else if (ph == 3) begin
      if (cls == 0) begin
        aluFun = ir[13:9]; oa = ir[6:4]; ob = ir[3:1]; wf = ir[0]; rfFun = 3'b010;
        rfReg[3 - int'(ir[8:7])] = 1'b0;
      end else if (cls == 1) begin
        ma = 2'b11; rfFun = 3'b010;
        rfReg[3 - int'(ir[9:8])] = 1'b0;
      end else if (cls == 2 && (ir[13] == 1'b0 || z == 1'b1)) begin
        mb = 2'b11; arfFun = 3'b010; arfReg = 3'b011;
      end
    end
    return {oa, ob, rfFun, rfReg, scr, aluFun, wf, oc, od, arfFun, arfReg,
            lh, irw, wr, cs, ma, mb, mc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h (phase %0d)", tag, obs, exp, phase);
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, advance the model at posedge.
  task automatic tick(input logic st, input logic [15:0] ir, input logic z,
                      input logic rs, input logic stp);
    @(negedge Clock);
    Start = st; IROut = ir; Z = z; Reset = rs; StepIn = stp;
    if (rs) begin phase = 0; prevStep = 1'b0; end
    #1;
    check("ctrl", {22'd0, obsCtrl}, {22'd0, modelCtrl(phase, ir, z)});
    check("busy", {63'd0, Busy}, {63'd0, 1'(phase >= 1 && phase <= 3)});
    check("halted", {63'd0, Halted}, {63'd0, 1'(phase == 4)});
    @(posedge Clock);
    if (!rs) begin
      case (phase)
        0: if (st) phase = 1;
        1: phase = 2;
        2: phase = 3;
        3: phase = (ir[15:14] == 2'b11) ? 4 : (STEP_MODE ? 5 : 1);
        5: if (STEP_MODE && stp && !prevStep) phase = 1;
        default: ;
      endcase
      prevStep = stp;
    end
  endtask

  task automatic runInstr(input logic [15:0] ir, input logic z);
    for (int i = 0; i < 3; i++) tick(1'b1, ir, z, 1'b0, 1'b0);
    tick(1'b1, ir, z, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] rir;
    logic        stepLvl = 1'b0;
    // Reset state, then reset asserted during fetch-high.
    tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    // Directed instruction classes.
    runInstr(16'h415A, 1'b0);
    runInstr(16'h2A90, 1'b1);
    runInstr(16'h2A91, 1'b0);
    runInstr(16'hA010, 1'b0);
    runInstr(16'hA010, 1'b1);
    runInstr(16'h8010, 1'b0);
    runInstr(16'h437F, 1'b1);
    runInstr(16'h0180, 1'b0);
    runInstr(16'hC000, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 16'h415A, 1'b1, 1'b0, 1'(i % 2));
    tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    // Randomized traffic with occasional resets and halts.
    for (int i = 0; i < 1500; i++) begin
      rir = 16'($urandom);
      if ($urandom_range(0, 15) == 0) rir[15:14] = 2'b11;
      else                            rir[15:14] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) stepLvl = ~stepLvl;
      tick(1'($urandom_range(0, 3) != 0), rir, 1'($urandom), 1'($urandom_range(0, 39) == 0),
           stepLvl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
